tlc_light_monitor: RTL and testbench

TLC_LIGHT_MONITOR -- requirements
Module: tlc_light_monitor

---
 rtl/tlc_pkg.sv | 16 +
 rtl/tlc_phase_timer.sv | 39 +++
 rtl/tlc_light_monitor.sv | 170 +++++++++++++++++
 tb/tb_tlc_light_monitor.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared encodings for the traffic-light monitor: tracked phase, error code, counter width.
package tlc_pkg;

   localparam int CNT_W = 8;

   localparam logic [1:0] PH_IDLE   = 2'd0;
   localparam logic [1:0] PH_RED    = 2'd1;
   localparam logic [1:0] PH_GREEN  = 2'd2;
   localparam logic [1:0] PH_YELLOW = 2'd3;

   localparam logic [1:0] EC_NONE   = 2'd0;
   localparam logic [1:0] EC_ONEHOT = 2'd1;
   localparam logic [1:0] EC_SEQ    = 2'd2;
   localparam logic [1:0] EC_TIMING = 2'd3;

endpackage

// File: rtl/tlc_phase_timer.sv
// Saturating phase-length counter plus the expected-duration compare.
// The compare exists only when TLC_MON_TIMING_CHECK_EN is defined.
module tlc_phase_timer
   import tlc_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic             i_inc,
   input  logic [CNT_W-1:0] i_exp,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_at_exp
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (i_clear)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= CNT_W'(1);
      else if (i_inc && (r_cnt != {CNT_W{1'b1}}))
         r_cnt <= r_cnt + CNT_W'(1);
   end

   assign o_cnt = r_cnt;

`ifdef TLC_MON_TIMING_CHECK_EN
   assign o_at_exp = (r_cnt == i_exp);
`else
   logic w_unused_exp;
   assign w_unused_exp = ^i_exp;
   assign o_at_exp     = 1'b0;
`endif

endmodule

// File: rtl/tlc_light_monitor.sv
// Traffic-light controller monitor: phase FSM, error capture and legal-cycle counter.
// Duration checks are built only when TLC_MON_TIMING_CHECK_EN is defined.
module tlc_light_monitor
   import tlc_pkg::*;
#(
   parameter int RED_CYC = 5,
   parameter int GRN_CYC = 4,
   parameter int YEL_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        red,
   input  logic        yellow,
   input  logic        green,
   output logic [1:0]  phase,
   output logic        err,
   output logic        err_pulse,
   output logic [1:0]  err_code,
   output logic [15:0] cycles
);

   logic [1:0]       r_phase;
   logic             r_partial;
   logic             r_clean;
   logic             r_over_done;
   logic             r_hist_r;
   logic             r_hist_g;
   logic             r_err;
   logic             r_err_pulse;
   logic [1:0]       r_err_code;
   logic [15:0]      r_cycles;

   logic             w_onehot;
   logic [1:0]       w_light;
   logic             w_same;
   logic             w_legal;
   logic [CNT_W-1:0] w_exp;
   logic [CNT_W-1:0] w_cnt;
   logic             w_at_exp;
   logic             w_over_raw;
   logic             w_exit_raw;
   logic             w_t_over;
   logic             w_t_exit;
   logic             w_e_seq;
   logic             w_err_any;
   logic [1:0]       w_code;

   assign w_onehot = $onehot({red, yellow, green});

   always_comb begin
      w_light = PH_YELLOW;
      if (red)        w_light = PH_RED;
      else if (green) w_light = PH_GREEN;
   end

   always_comb begin
      w_exp = CNT_W'(YEL_CYC);
      case (r_phase)
         PH_RED:   w_exp = CNT_W'(RED_CYC);
         PH_GREEN: w_exp = CNT_W'(GRN_CYC);
         default:  w_exp = CNT_W'(YEL_CYC);
      endcase
   end

   assign w_same  = w_onehot && (r_phase == w_light);
   assign w_legal = w_onehot && (((r_phase == PH_RED)    && (w_light == PH_GREEN))  ||
                                 ((r_phase == PH_GREEN)  && (w_light == PH_YELLOW)) ||
                                 ((r_phase == PH_YELLOW) && (w_light == PH_RED)));
   assign w_e_seq = w_onehot && (r_phase != PH_IDLE) && !w_same && !w_legal;

`ifdef TLC_MON_TIMING_CHECK_EN
   // Overstay fires when the count already equals the duration and the light is still on.
   assign w_over_raw = w_same && w_at_exp;
   assign w_exit_raw = w_legal && !w_at_exp;
`else
   logic w_unused_at;
   assign w_unused_at = w_at_exp;
   assign w_over_raw  = 1'b0;
   assign w_exit_raw  = 1'b0;
`endif

   assign w_t_over  = w_over_raw && !r_over_done;
   assign w_t_exit  = w_exit_raw && !r_partial;
   assign w_err_any = !w_onehot || w_e_seq || w_t_over || w_t_exit;

   always_comb begin
      w_code = EC_TIMING;
      if (!w_onehot)    w_code = EC_ONEHOT;
      else if (w_e_seq) w_code = EC_SEQ;
   end

   tlc_phase_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (!w_onehot),
      .i_load   (w_onehot && !w_same),
      .i_inc    (w_same),
      .i_exp    (w_exp),
      .o_cnt    (w_cnt),
      .o_at_exp (w_at_exp)
   );

   // r_clean marks an occurrence that may count toward a completed cycle; a red entered
   // from IDLE still qualifies so the first full cycle after start-up is credited.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase     <= PH_IDLE;
         r_partial   <= 1'b0;
         r_clean     <= 1'b0;
         r_over_done <= 1'b0;
         r_hist_r    <= 1'b0;
         r_hist_g    <= 1'b0;
         r_cycles    <= '0;
      end else if (!w_onehot) begin
         r_phase     <= PH_IDLE;
         r_partial   <= 1'b0;
         r_clean     <= 1'b0;
         r_over_done <= 1'b0;
         r_hist_r    <= 1'b0;
         r_hist_g    <= 1'b0;
      end else if (r_phase == PH_IDLE) begin
         r_phase     <= w_light;
         r_partial   <= 1'b1;
         r_clean     <= (w_light == PH_RED);
         r_over_done <= 1'b0;
      end else if (w_same) begin
         if (w_t_over) begin
            r_clean     <= 1'b0;
            r_over_done <= 1'b1;
         end
      end else begin
         r_phase     <= w_light;
         r_partial   <= 1'b0;
         r_clean     <= w_legal;
         r_over_done <= 1'b0;
         if (!w_legal) begin
            r_hist_r <= 1'b0;
            r_hist_g <= 1'b0;
         end else if (r_phase == PH_RED) begin
            r_hist_r <= r_clean && !w_t_exit;
         end else if (r_phase == PH_GREEN) begin
            r_hist_g <= r_clean && !w_t_exit;
         end else if (r_clean && !w_t_exit && r_hist_r && r_hist_g) begin
            r_cycles <= r_cycles + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err       <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err_code  <= EC_NONE;
      end else begin
         r_err_pulse <= w_err_any;
         if (w_err_any) begin
            r_err <= 1'b1;
            if (!r_err)
               r_err_code <= w_code;
         end
      end
   end

   assign phase     = r_phase;
   assign err       = r_err;
   assign err_pulse = r_err_pulse;
   assign err_code  = r_err_code;
   assign cycles    = r_cycles;

endmodule

// File: tb/tb_tlc_light_monitor.sv
// Directed bench for tlc_light_monitor (RED 5 / GREEN 4 / YELLOW 2).
// Expectations adapt to whether TLC_MON_TIMING_CHECK_EN is defined.
module tb_tlc_light_monitor;

`ifdef TLC_MON_TIMING_CHECK_EN
   localparam logic TIM = 1'b1;
`else
   localparam logic TIM = 1'b0;
`endif
   localparam logic [1:0] TCODE = TIM ? 2'd3 : 2'd0;

   logic        clk;
   logic        rst;
   logic        red;
   logic        yellow;
   logic        green;
   logic [1:0]  phase;
   logic        err;
   logic        err_pulse;
   logic [1:0]  err_code;
   logic [15:0] cycles;

   int vectors     = 0;
   int miscompares = 0;

   tlc_light_monitor #(
      .RED_CYC (5),
      .GRN_CYC (4),
      .YEL_CYC (2)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .red       (red),
      .yellow    (yellow),
      .green     (green),
      .phase     (phase),
      .err       (err),
      .err_pulse (err_pulse),
      .err_code  (err_code),
      .cycles    (cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [1:0] ph, input logic e,
                             input logic p, input logic [1:0] c, input logic [15:0] cyc);
      chk({tag, ".phase"},     16'(phase),     16'(ph));
      chk({tag, ".err"},       16'(err),       16'(e));
      chk({tag, ".err_pulse"}, 16'(err_pulse), 16'(p));
      chk({tag, ".err_code"},  16'(err_code),  16'(c));
      chk({tag, ".cycles"},    cycles,         cyc);
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
   task automatic step(input logic r, input logic y, input logic g);
      red    = r;
      yellow = y;
      green  = g;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input logic r, input logic y, input logic g, input int n);
      for (int i = 0; i < n; i++) step(r, y, g);
   endtask

   task automatic do_reset(input string tag);
      rst    = 1'b1;
      red    = 1'b0;
      yellow = 1'b0;
      green  = 1'b0;
      #1;
      expect_out(tag, 2'd0, 1'b0, 1'b0, 2'd0, 16'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst    = 1'b0;
      red    = 1'b0;
      yellow = 1'b0;
      green  = 1'b0;
      #2;

      // Clean cycle: credited at the yellow-to-red edge.
      do_reset("rst0");
      run(1, 0, 0, 5);
      chk("a_red.phase", 16'(phase), 16'd1);
      run(0, 0, 1, 4);
      chk("a_grn.phase", 16'(phase), 16'd2);
      run(0, 1, 0, 2);
      expect_out("a_yel", 2'd3, 1'b0, 1'b0, 2'd0, 16'd0);
      step(1, 0, 0);
      expect_out("a_r1", 2'd1, 1'b0, 1'b0, 2'd0, 16'd1);
      run(1, 0, 0, 4);
      expect_out("a_end", 2'd1, 1'b0, 1'b0, 2'd0, 16'd1);

      // Two lights, then recovery, then all-off.
      do_reset("rst_b");
      run(1, 0, 0, 2);
      step(1, 0, 1);
      expect_out("b_two", 2'd0, 1'b1, 1'b1, 2'd1, 16'd0);
      step(1, 0, 0);
      expect_out("b_rec", 2'd1, 1'b1, 1'b0, 2'd1, 16'd0);
      step(0, 0, 0);
      expect_out("b_off", 2'd0, 1'b1, 1'b1, 2'd1, 16'd0);

      // Green straight to red after a counted cycle.
      do_reset("rst_c");
      run(1, 0, 0, 5);
      run(0, 0, 1, 4);
      run(0, 1, 0, 2);
      run(1, 0, 0, 5);
      chk("c_pre.cycles", cycles, 16'd1);
      run(0, 0, 1, 4);
      step(1, 0, 0);
      expect_out("c_seq", 2'd1, 1'b1, 1'b1, 2'd2, 16'd1);
      run(1, 0, 0, 4);
      run(0, 0, 1, 4);
      run(0, 1, 0, 2);
      step(1, 0, 0);
      expect_out("c_after", 2'd1, 1'b1, 1'b0, 2'd2, 16'd1);

      // Red held 7 samples: overstay reported on the 6th only.
      do_reset("rst_d");
      run(1, 0, 0, 5);
      expect_out("d_r5", 2'd1, 1'b0, 1'b0, 2'd0, 16'd0);
      step(1, 0, 0);
      expect_out("d_r6", 2'd1, TIM, TIM, TCODE, 16'd0);
      step(1, 0, 0);
      expect_out("d_r7", 2'd1, TIM, 1'b0, TCODE, 16'd0);

      // Green one cycle short: exit timing error blocks the cycle credit.
      do_reset("rst_e");
      run(1, 0, 0, 5);
      run(0, 0, 1, 3);
      step(0, 1, 0);
      expect_out("e_gy", 2'd3, TIM, TIM, TCODE, 16'd0);
      step(0, 1, 0);
      step(1, 0, 0);
      expect_out("e_yr", 2'd1, TIM, 1'b0, TCODE, TIM ? 16'd0 : 16'd1);

      // Reset mid-green: the resumed green is partial, so nothing is credited.
      do_reset("rst_f");
      run(1, 0, 0, 5);
      run(0, 0, 1, 2);
      chk("f_pre.phase", 16'(phase), 16'd2);
      do_reset("f_mid");
      run(0, 0, 1, 2);
      run(0, 1, 0, 2);
      step(1, 0, 0);
      expect_out("f_end", 2'd1, 1'b0, 1'b0, 2'd0, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
